// File: rtl/sort_engine.sv
// Put/get sorting responder: loads N words, odd-even transposition sorts them (signed), serves them in order.
// Optional SORT_EARLY_EXIT_EN ends the sort after two consecutive swap-free phases.
module sort_engine #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] put_x,
  input  logic         EN_put,
  output logic         RDY_put,
  input  logic         EN_get,
  output logic [W-1:0] get,
  output logic         RDY_get
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned IW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  phase_q, phase_d;
  logic [W-1:0]   buf_q [N];
  logic [W-1:0]   buf_d [N];
`ifdef SORT_EARLY_EXIT_EN
  logic [1:0]     clean_q, clean_d;
  logic           swapped;
`endif

  // Next-state, counter and buffer update for load / sort phase / drain
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    buf_d   = buf_q;
`ifdef SORT_EARLY_EXIT_EN
    clean_d = clean_q;
    swapped = 1'b0;
`endif
    case (state_q)
      LOAD: begin
        if (EN_put) begin
          buf_d[IW'(cnt_q)] = put_x;
          if (cnt_q == LAST) begin
            state_d = SORT;
            cnt_d   = '0;
            phase_d = '0;
`ifdef SORT_EARLY_EXIT_EN
            clean_d = 2'd0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      SORT: begin
        // Pairs are disjoint within a phase, so every compare reads the pre-phase values
        for (int unsigned i = 0; i < N - 1; i++) begin
          if (1'(i) == phase_q[0] &&
              $signed(buf_q[IW'(i)]) > $signed(buf_q[IW'(i + 1)])) begin
            buf_d[IW'(i)]     = buf_q[IW'(i + 1)];
            buf_d[IW'(i + 1)] = buf_q[IW'(i)];
`ifdef SORT_EARLY_EXIT_EN
            swapped = 1'b1;
`endif
          end
        end
        phase_d = phase_q + CW'(1);
`ifdef SORT_EARLY_EXIT_EN
        clean_d = swapped ? 2'd0 : clean_q + 2'd1;
        if (phase_q == LAST || (!swapped && clean_q == 2'd1)) begin
`else
        if (phase_q == LAST) begin
`endif
          state_d = DRAIN;
          phase_d = '0;
        end
      end
      DRAIN: begin
        if (EN_get) begin
          if (cnt_q == LAST) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      phase_q <= '0;
`ifdef SORT_EARLY_EXIT_EN
      clean_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
`ifdef SORT_EARLY_EXIT_EN
      clean_q <= clean_d;
`endif
    end
  end

  // Data storage needs no reset: it is always fully written before it is read
  always_ff @(posedge CLK) begin
    buf_q <= buf_d;
  end

  assign RDY_put = (state_q == LOAD);
  assign RDY_get = (state_q == DRAIN);
  assign get     = (state_q == DRAIN) ? buf_q[IW'(cnt_q)] : '0;

endmodule

// File: tb/tb_sort_engine.sv
// Scoreboard bench for sort_engine (N=5, W=32): expected sorted words queued at load, compared at each get.
module tb_sort_engine;

  localparam int unsigned N = 5;
  localparam int unsigned W = 32;

  logic         CLK;
  logic         RST_N;
  logic [W-1:0] put_x;
  logic         EN_put;
  logic         RDY_put;
  logic         EN_get;
  logic [W-1:0] get;
  logic         RDY_get;

  int errors;
  int checks;
  logic [W-1:0] exp_q [$];

  sort_engine #(.N(N), .W(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .put_x(put_x), .EN_put(EN_put), .RDY_put(RDY_put),
    .EN_get(EN_get), .get(get), .RDY_get(RDY_get)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Independent reference: insertion sort by signed value, pushed to the scoreboard
  task automatic model_push(input logic [W-1:0] b [N]);
    logic [W-1:0] s [N];
    logic [W-1:0] t;
    s = b;
    for (int i = 1; i < int'(N); i++) begin
      for (int j = i; j > 0; j--) begin
        if ($signed(s[j-1]) > $signed(s[j])) begin
          t = s[j-1]; s[j-1] = s[j]; s[j] = t;
        end
      end
    end
    for (int i = 0; i < int'(N); i++) exp_q.push_back(s[i]);
  endtask

  // Puts N words back to back; optionally holds EN_get high during the load
  task automatic load_batch(input logic [W-1:0] b [N], input bit abuse_get);
    for (int i = 0; i < int'(N); i++) begin
      @(negedge CLK);
      checks++;
      if (RDY_put !== 1'b1) begin
        errors++; $display("FAIL load_rdy_put word %0d: got %b want 1", i, RDY_put);
      end
      put_x  = b[i];
      EN_put = 1'b1;
      EN_get = abuse_get;
      @(posedge CLK);
    end
    model_push(b);
    #1;
    EN_put = 1'b0;
    put_x  = '0;
  endtask

  // Counts edges from the Nth put edge to the first edge that sees RDY_get=1; RDY_put must stay 0
  task automatic measure_latency(input int lo, input int hi, input bit abuse_first);
    int  n;
    bit  r;
    n = 0;
    do begin
      @(negedge CLK);
      EN_get = (abuse_first && n == 0);
      r = RDY_get;
      checks++;
      if (RDY_put !== 1'b0) begin
        errors++; $display("FAIL sort_rdy_put cycle %0d: got %b want 0", n, RDY_put);
      end
      @(posedge CLK);
      n++;
    end while (!r && n < 30);
    #1;
    EN_get = 1'b0;
    checks++;
    if (n < lo || n > hi) begin
      errors++; $display("FAIL latency: got %0d edges want %0d..%0d", n, lo, hi);
    end
  endtask

  // Pops and compares N words, then checks RDY_put is back the cycle after the last get
  task automatic drain_batch(input string tag);
    logic [W-1:0] e;
    for (int i = 0; i < int'(N); i++) begin
      @(negedge CLK);
      checks++;
      if (RDY_get !== 1'b1 || RDY_put !== 1'b0) begin
        errors++; $display("FAIL %s drain_rdy word %0d: got get/put=%b%b want 10", tag, i, RDY_get, RDY_put);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL %s scoreboard_empty word %0d: got %0d want entry", tag, i, $signed(get));
      end else begin
        e = exp_q.pop_front();
        if (get !== e) begin
          errors++; $display("FAIL %s data word %0d: got %0d want %0d", tag, i, $signed(get), $signed(e));
        end
      end
      EN_get = 1'b1;
      @(posedge CLK);
      #1;
      EN_get = 1'b0;
    end
    checks++;
    if (RDY_put !== 1'b1 || RDY_get !== 1'b0 || get !== '0) begin
      errors++; $display("FAIL %s post_drain: got put/get/data=%b/%b/%0h want 1/0/0", tag, RDY_put, RDY_get, get);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; EN_put = 1'b0; EN_get = 1'b0; put_x = '0;
    #1;
    checks++;
    if (RDY_put !== 1'b1 || RDY_get !== 1'b0 || get !== '0) begin
      errors++; $display("FAIL reset: got put/get/data=%b/%b/%0h want 1/0/0", RDY_put, RDY_get, get);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_lfsr();
    logic [W-1:0] v [N];
    v = '{32'd1, 32'd142, 32'd71, 32'd173, 32'd216};
    load_batch(v, 1'b0);
`ifdef SORT_EARLY_EXIT_EN
    measure_latency(3, 6, 1'b0);
`else
    measure_latency(6, 6, 1'b0);
`endif
    drain_batch("lfsr");
  endtask

  task automatic test_reverse_back_to_back();
    logic [W-1:0] v [N];
    v = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    load_batch(v, 1'b0);
`ifdef SORT_EARLY_EXIT_EN
    measure_latency(3, 6, 1'b0);
`else
    measure_latency(6, 6, 1'b0);
`endif
    drain_batch("reverse");
    v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    load_batch(v, 1'b0);
`ifdef SORT_EARLY_EXIT_EN
    measure_latency(3, 3, 1'b0);
`else
    measure_latency(6, 6, 1'b0);
`endif
    drain_batch("sorted");
  endtask

  task automatic test_signed_dups();
    logic [W-1:0] v [N];
    v = '{-32'sd3, 32'sd7, 32'sd0, -32'sd128, 32'sd2};
    load_batch(v, 1'b0);
    measure_latency(2, 6, 1'b0);
    drain_batch("signed");
    v = '{32'd9, 32'd9, 32'd1, 32'd9, 32'd1};
    load_batch(v, 1'b0);
    measure_latency(2, 6, 1'b0);
    drain_batch("dups");
    v = '{32'h7fffffff, 32'h80000000, 32'h00000000, 32'hffffffff, 32'h00000001};
    load_batch(v, 1'b0);
    measure_latency(2, 6, 1'b0);
    drain_batch("extremes");
  endtask

  task automatic test_protocol_abuse();
    logic [W-1:0] v [N];
    v = '{32'd30, -32'sd1, 32'd12, 32'd7, -32'sd50};
    load_batch(v, 1'b1);
    measure_latency(2, 6, 1'b1);
    // Spurious puts while draining must not disturb the sorted data
    repeat (2) begin
      @(negedge CLK);
      EN_put = 1'b1;
      put_x  = 32'hdeadbeef;
      @(posedge CLK);
      #1;
      EN_put = 1'b0;
      checks++;
      if (RDY_get !== 1'b1 || get !== exp_q[0]) begin
        errors++; $display("FAIL abuse_put_in_drain: got rdy=%b data=%0d want 1/%0d", RDY_get, $signed(get), $signed(exp_q[0]));
      end
    end
    drain_batch("abuse");
  endtask

  task automatic test_reset_mid_sort();
    logic [W-1:0] v [N];
    v = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    load_batch(v, 1'b0);
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (RDY_put !== 1'b1 || RDY_get !== 1'b0 || get !== '0) begin
      errors++; $display("FAIL reset_mid_sort: got put/get/data=%b/%b/%0h want 1/0/0", RDY_put, RDY_get, get);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    v = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
    load_batch(v, 1'b0);
`ifdef SORT_EARLY_EXIT_EN
    measure_latency(3, 3, 1'b0);
`else
    measure_latency(6, 6, 1'b0);
`endif
    drain_batch("after_reset");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_lfsr();
    test_reverse_back_to_back();
    test_signed_dups();
    test_protocol_abuse();
    test_reset_mid_sort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion want finish");
    $fatal(1);
  end

endmodule
